// File: rtl/usb_arb_pkg.sv
// rtl/usb_arb_pkg.sv - shared state encoding, header tag and index-width helper for the packet arbiter
package usb_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_XFER = 2'd2
    } arb_state_t;

    localparam logic [7:0] HDR_TAG = 8'hA5;

    // Width of a source index; a single bit even for one or two sources.
    function automatic int src_idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/usb_rr_pick.sv
// rtl/usb_rr_pick.sv - combinational round-robin search starting after the last granted source
module usb_rr_pick
    import usb_arb_pkg::*;
#(
    parameter int N_SRC = 2,
    parameter int IW    = src_idx_w(N_SRC)
) (
    input  logic [N_SRC-1:0] req,
    input  logic [IW-1:0]    last_grant,
    output logic [N_SRC-1:0] gnt_oh,
    output logic [IW-1:0]    gnt_idx,
    output logic             any
);

    int cand;

    // Walk the sources from last_grant+1 around to last_grant itself; first requester wins.
    always_comb begin
        gnt_oh  = '0;
        gnt_idx = '0;
        any     = 1'b0;
        cand    = 0;
        for (int i = 1; i <= N_SRC; i++) begin
            cand = (int'(last_grant) + i) % N_SRC;
            if (!any && req[cand]) begin
                any          = 1'b1;
                gnt_oh[cand] = 1'b1;
                gnt_idx      = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/usb_packet_arbiter.sv
// rtl/usb_packet_arbiter.sv - round-robin packet-boundary arbiter; USB_ARB_HEADER_EN adds a per-packet header word
module usb_packet_arbiter
    import usb_arb_pkg::*;
#(
    parameter int N_SRC = 2,
    parameter int DW    = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_SRC*DW-1:0] s_data_i,
    input  logic [N_SRC-1:0]   s_valid_i,
    input  logic [N_SRC-1:0]   s_last_i,
    output logic [N_SRC-1:0]   s_ready_o,
    output logic [DW-1:0]      m_data_o,
    output logic               m_valid_o,
    output logic               m_last_o,
    input  logic               m_ready_i,
    output logic [N_SRC-1:0]   grant_o
);

    localparam int IW = src_idx_w(N_SRC);

    arb_state_t        state;
    arb_state_t        state_nx;
    logic [IW-1:0]     last_grant;
    logic [IW-1:0]     gidx;
    logic [N_SRC-1:0]  pick_oh;
    logic [IW-1:0]     pick_idx;
    logic              pick_any;
    logic [DW-1:0]     sel_data;
    logic              sel_valid;
    logic              sel_last;
    logic              pkt_end;

    usb_rr_pick #(
        .N_SRC (N_SRC),
        .IW    (IW)
    ) u_pick (
        .req        (s_valid_i),
        .last_grant (last_grant),
        .gnt_oh     (pick_oh),
        .gnt_idx    (pick_idx),
        .any        (pick_any)
    );

    assign sel_data  = s_data_i[gidx*DW +: DW];
    assign sel_valid = s_valid_i[gidx];
    assign sel_last  = s_last_i[gidx];

    // State register; reset abandons any packet in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state and the merged-stream mux; everything is quiet outside an owned packet.
    always_comb begin
        state_nx  = state;
        m_data_o  = '0;
        m_valid_o = 1'b0;
        m_last_o  = 1'b0;
        s_ready_o = '0;
        pkt_end   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pick_any) begin
`ifdef USB_ARB_HEADER_EN
                    state_nx = ST_HDR;
`else
                    state_nx = ST_XFER;
`endif
                end
            end
`ifdef USB_ARB_HEADER_EN
            ST_HDR: begin
                m_data_o  = {HDR_TAG, (DW-8)'(gidx)};
                m_valid_o = 1'b1;
                if (m_ready_i) begin
                    state_nx = ST_XFER;
                end
            end
`endif
            ST_XFER: begin
                m_data_o  = sel_data;
                m_valid_o = sel_valid;
                m_last_o  = sel_last;
                s_ready_o = {{(N_SRC-1){1'b0}}, m_ready_i} << gidx;
                if (sel_valid && sel_last && m_ready_i) begin
                    pkt_end  = 1'b1;
                    state_nx = ST_IDLE;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // Ownership registers: captured when leaving IDLE, released on the final beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gidx       <= '0;
            grant_o    <= '0;
            last_grant <= IW'(N_SRC-1);
        end else begin
            if (state == ST_IDLE && pick_any) begin
                gidx    <= pick_idx;
                grant_o <= pick_oh;
            end
            if (pkt_end) begin
                grant_o    <= '0;
                last_grant <= gidx;
            end
        end
    end

endmodule

// File: tb/tb_usb_packet_arbiter.sv
// tb/tb_usb_packet_arbiter.sv - scoreboard bench for usb_packet_arbiter with two 16-bit sources
module tb_usb_packet_arbiter;

    localparam int N_SRC = 2;
    localparam int DW    = 16;

    typedef struct {
        int          n;
        logic [15:0] base;
        int          gap_at;
        int          gap_len;
    } pkt_t;

    logic                  clk = 1'b0;
    logic                  rst_n;
    wire  [N_SRC*DW-1:0]   s_data_i;
    wire  [N_SRC-1:0]      s_valid_i;
    wire  [N_SRC-1:0]      s_last_i;
    logic [N_SRC-1:0]      s_ready_o;
    logic [DW-1:0]         m_data_o;
    logic                  m_valid_o;
    logic                  m_last_o;
    logic                  m_ready_i;
    logic [N_SRC-1:0]      grant_o;

    pkt_t        pq   [N_SRC][$];
    logic [16:0] expq [N_SRC][$];
    int          gq[$];

    int n_checks = 0;
    int n_fail   = 0;

    bit bp_mode = 1'b0;
    bit strict  = 1'b0;

    int cyc = 0, last_end = 0, prev_beat = 0, beats_seen = 0, stall_cnt = 0;
    bit in_pkt = 1'b0, chk_idle = 1'b0, ended_once = 1'b0, strict_q = 1'b0;
    logic [N_SRC-1:0] cur_oh = '0;

    usb_packet_arbiter #(
        .N_SRC (N_SRC),
        .DW    (DW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_data_i  (s_data_i),
        .s_valid_i (s_valid_i),
        .s_last_i  (s_last_i),
        .s_ready_o (s_ready_o),
        .m_data_o  (m_data_o),
        .m_valid_o (m_valid_o),
        .m_last_o  (m_last_o),
        .m_ready_i (m_ready_i),
        .grant_o   (grant_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Per-source packet drivers: present beats at negedge, record expectations as they are driven.
    for (genvar k = 0; k < N_SRC; k++) begin : g_src
        logic [DW-1:0] d;
        logic          v;
        logic          l;
        assign s_data_i[k*DW +: DW] = d;
        assign s_valid_i[k]         = v;
        assign s_last_i[k]          = l;

        initial begin : drv
            pkt_t p;
            int   i;
            int   tmo;
            bit   hs;
            bit   abort;
            d = '0;
            v = 1'b0;
            l = 1'b0;
            forever begin
                @(negedge clk);
                if (!rst_n || pq[k].size() == 0) begin
                    v = 1'b0;
                    l = 1'b0;
                end else begin
                    p     = pq[k].pop_front();
                    abort = 1'b0;
                    i     = 0;
                    while (i < p.n && !abort) begin
                        if (i == p.gap_at && p.gap_len > 0) begin
                            v = 1'b0;
                            l = 1'b0;
                            repeat (p.gap_len) @(negedge clk);
                        end
                        d = p.base + 16'(i);
                        v = 1'b1;
                        l = (i == p.n - 1);
                        expq[k].push_back({l, d});
                        tmo = 0;
                        forever begin
                            #1;
                            hs = s_ready_o[k];
                            @(posedge clk);
                            if (!rst_n) begin
                                abort = 1'b1;
                                break;
                            end
                            if (hs) break;
                            @(negedge clk);
                            tmo++;
                            if (tmo > 500) begin
                                check("beat_timeout", tmo, 0);
                                abort = 1'b1;
                                break;
                            end
                        end
                        i++;
                        if (!abort && i < p.n) @(negedge clk);
                    end
                    if (abort) begin
                        v = 1'b0;
                        l = 1'b0;
                        pq[k].delete();
                        expq[k].delete();
                    end
                end
            end
        end
    end

    // Downstream ready: steady high, or alternating while backpressure is exercised.
    initial begin
        m_ready_i = 1'b1;
        forever begin
            @(negedge clk);
            m_ready_i = bp_mode ? ~m_ready_i : 1'b1;
        end
    end

    // Output monitor: sampled ahead of each rising edge, compares against the scoreboard.
    always @(negedge clk) begin
        int          src;
        bit          first;
        bit          hdr_beat;
        logic [16:0] e;
        #3;
        cyc++;
        if (strict && !strict_q) ended_once = 1'b0;
        strict_q = strict;
        if (!rst_n) begin
            in_pkt   = 1'b0;
            chk_idle = 1'b0;
        end else begin
            if (chk_idle) begin
                check("bubble_valid", m_valid_o, 0);
                check("bubble_grant", grant_o, 0);
                chk_idle = 1'b0;
            end
            if (in_pkt) begin
                check("other_ready", s_ready_o & ~cur_oh, 0);
                if (!m_valid_o) begin
                    stall_cnt++;
                    check("hold_grant", grant_o, cur_oh);
                end
            end
            if (m_valid_o && m_ready_i) begin
                check("grant_onehot", $countones(grant_o), 1);
                src      = grant_o[1] ? 1 : 0;
                first    = !in_pkt;
                hdr_beat = 1'b0;
                if (first) begin
                    if (gq.size() > 0) check("grant_order", src, gq.pop_front());
                    else check("grant_expected", 0, 1);
                    if (strict && ended_once) check("bubble_len", cyc - last_end, 2);
                    in_pkt = 1'b1;
                    cur_oh = grant_o;
`ifdef USB_ARB_HEADER_EN
                    hdr_beat = 1'b1;
                    check("hdr_word", m_data_o, {8'hA5, 8'(src)});
                    check("hdr_last", m_last_o, 0);
`endif
                end else if (strict) begin
                    check("contig", cyc - prev_beat, 1);
                end
                if (!hdr_beat) begin
                    beats_seen++;
                    if (expq[src].size() == 0) begin
                        check("beat_expected", 0, 1);
                    end else begin
                        e = expq[src].pop_front();
                        check("data", m_data_o, e[15:0]);
                        check("last", m_last_o, e[16]);
                    end
                    if (m_last_o) begin
                        in_pkt     = 1'b0;
                        chk_idle   = 1'b1;
                        last_end   = cyc;
                        ended_once = 1'b1;
                    end
                end
                prev_beat = cyc;
            end
        end
    end

    task automatic drain(input string tag, input int max);
        int t;
        t = 0;
        while ((pq[0].size() + pq[1].size() + expq[0].size() + expq[1].size() + gq.size()) != 0
               || in_pkt) begin
            @(posedge clk);
            t++;
            if (t > max) break;
        end
        check(tag, (t > max), 0);
        repeat (3) @(posedge clk);
    endtask

    task automatic wait_beats(input int target, input int max);
        int t;
        t = 0;
        while (beats_seen < target && t <= max) begin
            @(posedge clk);
            t++;
        end
        check("wait_beats_timeout", (t > max), 0);
    endtask

    task automatic push_pkt(input int src, input int n, input logic [15:0] base,
                            input int gap_at, input int gap_len);
        pkt_t p;
        p.n       = n;
        p.base    = base;
        p.gap_at  = gap_at;
        p.gap_len = gap_len;
        pq[src].push_back(p);
    endtask

    initial begin
        int s0;
        rst_n = 1'b0;

        repeat (2) @(negedge clk);
        #1;
        check("rst_m_valid", m_valid_o, 0);
        check("rst_m_last", m_last_o, 0);
        check("rst_m_data", m_data_o, 0);
        check("rst_grant", grant_o, 0);
        check("rst_s_ready", s_ready_o, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;

        // reset asserted in the middle of a source-1 packet
        @(posedge clk);
        #1;
        push_pkt(1, 4, 16'h1000, -1, 0);
        gq.push_back(1);
        wait_beats(2, 100);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_m_valid", m_valid_o, 0);
        check("midrst_m_last", m_last_o, 0);
        check("midrst_m_data", m_data_o, 0);
        check("midrst_grant", grant_o, 0);
        check("midrst_s_ready", s_ready_o, 0);
        gq.delete();
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;

        // both sources request after release: source 0 first
        @(posedge clk);
        #1;
        push_pkt(0, 2, 16'h2000, -1, 0);
        push_pkt(1, 2, 16'h2100, -1, 0);
        gq.push_back(0);
        gq.push_back(1);
        drain("drain_postrst", 300);

        // fairness with continuous 4-beat packets
        strict = 1'b1;
        @(posedge clk);
        #1;
        for (int j = 0; j < 3; j++) begin
            push_pkt(0, 4, 16'h3000 + 16'(j * 16), -1, 0);
            push_pkt(1, 4, 16'h3100 + 16'(j * 16), -1, 0);
            gq.push_back(0);
            gq.push_back(1);
        end
        drain("drain_fair", 500);
        strict = 1'b0;

        // alternating backpressure on a 3-beat source-1 packet
        bp_mode = 1'b1;
        @(posedge clk);
        #1;
        push_pkt(1, 3, 16'h0011, -1, 0);
        gq.push_back(1);
        drain("drain_bp", 300);
        bp_mode = 1'b0;

        // source 1 stalls for 5 cycles mid-packet while source 0 waits
        s0 = stall_cnt;
        @(posedge clk);
        #1;
        push_pkt(1, 4, 16'h4000, 2, 5);
        gq.push_back(1);
        gq.push_back(0);
        repeat (3) @(posedge clk);
        #1;
        push_pkt(0, 2, 16'h4100, -1, 0);
        drain("drain_gap", 300);
        check("gap_stalls", stall_cnt - s0, 5);

        // single-beat packet
        @(posedge clk);
        #1;
        push_pkt(1, 1, 16'hBEEF, -1, 0);
        gq.push_back(1);
        drain("drain_single", 200);

        check("exp_left", expq[0].size() + expq[1].size(), 0);
        check("grant_left", gq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected completion");
        $fatal(1);
    end

endmodule
